// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALUop codes, MIPS opcode/funct
// values, FSM states and the decoded request class.
package alu_issue_ctrl_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        CLS_ARITH_TRAP,
        CLS_ARITH,
        CLS_BEQ,
        CLS_BNE,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the issue controller; master is the
// controller itself, slave is the surrounding pipeline plus the external ALU.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [5:0]            req_opcode;
    logic [5:0]            req_funct;
    logic [DATA_WIDTH-1:0] req_rs_val;
    logic [DATA_WIDTH-1:0] req_rt_val;
    logic [15:0]           req_imm;

    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [2:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_branch_taken;
    logic                  rsp_ovf;
    logic                  rsp_illegal;

    modport master (
        input  req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
        output req_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero, alu_overflow,
        output rsp_valid, rsp_result, rsp_branch_taken, rsp_ovf, rsp_illegal,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_opcode, req_funct, req_rs_val, req_rt_val, req_imm,
        input  req_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero, alu_overflow,
        input  rsp_valid, rsp_result, rsp_branch_taken, rsp_ovf, rsp_illegal,
        output rsp_ready
    );

endinterface

// File: rtl/alu_issue_ctrl_alu_op_decode.sv
// Combinational decode of a MIPS ALU/branch-compare request into ALUop, operands
// and a response class.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [15:0]           imm,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    output logic [2:0]            op,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output op_class_t             cls
);

    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_zext;
    logic [DATA_WIDTH-1:0] imm_lui;

    assign imm_sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, imm};
    assign imm_lui  = {imm, {(DATA_WIDTH-16){1'b0}}};

    always_comb begin
        op  = ALU_AND;
        a   = '0;
        b   = '0;
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_SPECIAL: begin
                a   = rs_val;
                b   = rt_val;
                cls = CLS_ARITH;
                case (funct)
                    FN_ADD:  begin op = ALU_ADD; cls = CLS_ARITH_TRAP; end
                    FN_ADDU: op = ALU_ADD;
                    FN_SUB:  begin op = ALU_SUB; cls = CLS_ARITH_TRAP; end
                    FN_SUBU: op = ALU_SUB;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_XOR:  op = ALU_XOR;
                    FN_NOR:  op = ALU_NOR;
                    FN_SLT:  op = ALU_SLT;
                    FN_SLTU: op = ALU_SLTU;
                    default: begin
                        a   = '0;
                        b   = '0;
                        cls = CLS_ILLEGAL;
                    end
                endcase
            end
            OP_ADDI:  begin op = ALU_ADD;  a = rs_val; b = imm_sext; cls = CLS_ARITH_TRAP; end
            OP_ADDIU: begin op = ALU_ADD;  a = rs_val; b = imm_sext; cls = CLS_ARITH; end
            OP_SLTI:  begin op = ALU_SLT;  a = rs_val; b = imm_sext; cls = CLS_ARITH; end
            // sltiu sign-extends then compares unsigned, as MIPS defines it
            OP_SLTIU: begin op = ALU_SLTU; a = rs_val; b = imm_sext; cls = CLS_ARITH; end
            OP_ANDI:  begin op = ALU_AND;  a = rs_val; b = imm_zext; cls = CLS_ARITH; end
            OP_ORI:   begin op = ALU_OR;   a = rs_val; b = imm_zext; cls = CLS_ARITH; end
            OP_XORI:  begin op = ALU_XOR;  a = rs_val; b = imm_zext; cls = CLS_ARITH; end
            OP_LUI:   begin op = ALU_OR;   a = '0;     b = imm_lui;  cls = CLS_ARITH; end
            OP_BEQ:   begin op = ALU_SUB;  a = rs_val; b = rt_val;   cls = CLS_BEQ; end
            OP_BNE:   begin op = ALU_SUB;  a = rs_val; b = rt_val;   cls = CLS_BNE; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one request, drives the external ALU from
// registers for one cycle, then presents the captured result until consumed.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          TRAP_OVF   = 1'b1
) (
    input  logic           clk,
    input  logic           resetn,
    alu_issue_ctrl_if.master bus
);

    state_t                state;
    op_class_t             cls_q;
    logic                  req_ready_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [2:0]            alu_op_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_result_q;
    logic                  rsp_taken_q;
    logic                  rsp_ovf_q;
    logic                  rsp_illegal_q;

    logic [2:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    op_class_t             dec_cls;

    alu_op_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .opcode (bus.req_opcode),
        .funct  (bus.req_funct),
        .imm    (bus.req_imm),
        .rs_val (bus.req_rs_val),
        .rt_val (bus.req_rt_val),
        .op     (dec_op),
        .a      (dec_a),
        .b      (dec_b),
        .cls    (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            cls_q         <= CLS_ILLEGAL;
            req_ready_q   <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= ALU_AND;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_taken_q   <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        alu_a_q     <= dec_a;
                        alu_b_q     <= dec_b;
                        alu_op_q    <= dec_op;
                        cls_q       <= dec_cls;
                        req_ready_q <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // branches and illegal requests never write a value back
                    rsp_result_q  <= (cls_q == CLS_ARITH_TRAP || cls_q == CLS_ARITH)
                                     ? bus.alu_result : '0;
                    rsp_taken_q   <= (cls_q == CLS_BEQ &&  bus.alu_zero) ||
                                     (cls_q == CLS_BNE && !bus.alu_zero);
                    rsp_ovf_q     <= TRAP_OVF && (cls_q == CLS_ARITH_TRAP) && bus.alu_overflow;
                    rsp_illegal_q <= (cls_q == CLS_ILLEGAL);
                    rsp_valid_q   <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.alu_a            = alu_a_q;
    assign bus.alu_b            = alu_b_q;
    assign bus.alu_op           = alu_op_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_result       = rsp_result_q;
    assign bus.rsp_branch_taken = rsp_taken_q;
    assign bus.rsp_ovf          = rsp_ovf_q;
    assign bus.rsp_illegal      = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU attached
// to the controller's alu_* outputs.
module tb_alu_issue_ctrl;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    alu_issue_ctrl_if #(.DATA_WIDTH(32)) bus ();

    alu_issue_ctrl #(
        .DATA_WIDTH (32),
        .TRAP_OVF   (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_res;
    logic [31:0] m_sum;
    logic [31:0] m_diff;
    logic        m_ovf;

    always_comb begin
        m_sum  = bus.alu_a + bus.alu_b;
        m_diff = bus.alu_a - bus.alu_b;
        m_res  = '0;
        m_ovf  = 1'b0;
        case (bus.alu_op)
            3'b000: m_res = bus.alu_a & bus.alu_b;
            3'b001: m_res = bus.alu_a | bus.alu_b;
            3'b010: begin
                m_res = m_sum;
                m_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (m_sum[31] != bus.alu_a[31]);
            end
            3'b011: m_res = {31'b0, (bus.alu_a < bus.alu_b)};
            3'b100: m_res = bus.alu_a ^ bus.alu_b;
            3'b101: m_res = ~(bus.alu_a | bus.alu_b);
            3'b110: begin
                m_res = m_diff;
                m_ovf = (bus.alu_a[31] != bus.alu_b[31]) && (m_diff[31] != bus.alu_a[31]);
            end
            default: m_res = {31'b0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
        endcase
    end

    assign bus.alu_result   = m_res;
    assign bus.alu_zero     = (m_res == 32'h0);
    assign bus.alu_overflow = m_ovf;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Starts in IDLE, #1 after an edge; leaves the bench at the same phase.
    task automatic do_op(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                         input logic [2:0] e_op, input logic [31:0] e_a, input logic [31:0] e_b,
                         input logic [31:0] e_res, input logic e_taken, input logic e_ovf,
                         input logic e_ill, input bit drain);
        bus.req_opcode = opc;
        bus.req_funct  = fn;
        bus.req_rs_val = rs;
        bus.req_rt_val = rt;
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
        chk1({tag, ".req_ready_idle"}, bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk32({tag, ".alu_op"}, {29'b0, bus.alu_op}, {29'b0, e_op});
        chk32({tag, ".alu_a"}, bus.alu_a, e_a);
        chk32({tag, ".alu_b"}, bus.alu_b, e_b);
        chk1({tag, ".req_ready_exec"}, bus.req_ready, 1'b0);
        chk1({tag, ".rsp_valid_exec"}, bus.rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk1({tag, ".rsp_valid"}, bus.rsp_valid, 1'b1);
        chk32({tag, ".rsp_result"}, bus.rsp_result, e_res);
        chk1({tag, ".taken"}, bus.rsp_branch_taken, e_taken);
        chk1({tag, ".ovf"}, bus.rsp_ovf, e_ovf);
        chk1({tag, ".illegal"}, bus.rsp_illegal, e_ill);
        if (drain) begin
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            chk1({tag, ".rsp_valid_drained"}, bus.rsp_valid, 1'b0);
            chk1({tag, ".req_ready_back"}, bus.req_ready, 1'b1);
            chk32({tag, ".alu_op_held"}, {29'b0, bus.alu_op}, {29'b0, e_op});
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        resetn         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_funct  = '0;
        bus.req_rs_val = '0;
        bus.req_rt_val = '0;
        bus.req_imm    = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst.req_ready", bus.req_ready, 1'b1);
        chk1("rst.rsp_valid", bus.rsp_valid, 1'b0);
        chk32("rst.alu_a", bus.alu_a, 32'h0);
        chk32("rst.alu_b", bus.alu_b, 32'h0);
        chk32("rst.alu_op", {29'b0, bus.alu_op}, 32'h0);
        chk32("rst.rsp_result", bus.rsp_result, 32'h0);
        chk1("rst.taken", bus.rsp_branch_taken, 1'b0);
        chk1("rst.ovf", bus.rsp_ovf, 1'b0);
        chk1("rst.illegal", bus.rsp_illegal, 1'b0);
        resetn = 1'b1;
        @(posedge clk); #1;

        //     tag      opcode     funct      rs            rt            imm       op      a             b             result        tk    ovf   ill
        do_op("addi",  6'h08, 6'h00, 32'h00000005, 32'h0,        16'hFFFF, 3'b010, 32'h00000005, 32'hFFFFFFFF, 32'h00000004, 1'b0, 1'b0, 1'b0, 1);
        do_op("add",   6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001, 16'h0,    3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1);
        do_op("addu",  6'h00, 6'h21, 32'h7FFFFFFF, 32'h00000001, 16'h0,    3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 1);
        do_op("sub",   6'h00, 6'h22, 32'h80000000, 32'h00000001, 16'h0,    3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1);
        do_op("slti",  6'h0A, 6'h00, 32'hFFFFFFFE, 32'h0,        16'h0001, 3'b111, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        do_op("sltu",  6'h00, 6'h2B, 32'hFFFFFFFE, 32'h00000001, 16'h0,    3'b011, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
        do_op("sltiu", 6'h0B, 6'h00, 32'h00000005, 32'h0,        16'hFFFF, 3'b011, 32'h00000005, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        do_op("andi",  6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0,        16'h8000, 3'b000, 32'hFFFFFFFF, 32'h00008000, 32'h00008000, 1'b0, 1'b0, 1'b0, 1);
        do_op("beq",   6'h04, 6'h00, 32'h00001234, 32'h00001234, 16'h0,    3'b110, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        do_op("bne",   6'h05, 6'h00, 32'h00001234, 32'h00001234, 16'h0,    3'b110, 32'h00001234, 32'h00001234, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
        do_op("lui",   6'h0F, 6'h00, 32'hFFFFFFFF, 32'h0,        16'h1234, 3'b001, 32'h00000000, 32'h12340000, 32'h12340000, 1'b0, 1'b0, 1'b0, 1);
        do_op("illeg", 6'h3F, 6'h00, 32'hDEADBEEF, 32'hCAFEF00D, 16'h5555, 3'b000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 0);

        // Backpressure: a competing request must be ignored while RESP is held.
        bus.req_opcode = 6'h08;
        bus.req_rs_val = 32'h00000011;
        bus.req_imm    = 16'h0001;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk1("hold.rsp_valid", bus.rsp_valid, 1'b1);
            chk1("hold.req_ready", bus.req_ready, 1'b0);
            chk1("hold.illegal", bus.rsp_illegal, 1'b1);
            chk32("hold.rsp_result", bus.rsp_result, 32'h0);
            chk32("hold.alu_a", bus.alu_a, 32'h0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk1("hold.drained", bus.rsp_valid, 1'b0);
        chk1("hold.req_ready_back", bus.req_ready, 1'b1);

        // Reset while in EXEC discards the request.
        bus.req_opcode = 6'h00;
        bus.req_funct  = 6'h20;
        bus.req_rs_val = 32'h00000003;
        bus.req_rt_val = 32'h00000004;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk32("mrst.exec_alu_a", bus.alu_a, 32'h00000003);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk1("mrst.req_ready", bus.req_ready, 1'b1);
        chk1("mrst.rsp_valid", bus.rsp_valid, 1'b0);
        chk32("mrst.alu_a", bus.alu_a, 32'h0);
        chk32("mrst.alu_b", bus.alu_b, 32'h0);
        chk32("mrst.alu_op", {29'b0, bus.alu_op}, 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1("mrst.no_rsp", bus.rsp_valid, 1'b0);
            chk1("mrst.idle", bus.req_ready, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
